alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
//
// PURPOSE
// Initiator side of the Pre_Alu operand interface.
// - Accepts one operation request (A, B, Sel) per valid/ready handshake.
// - Drives the request onto a Pre_Alu instance and waits a fixed settle time.
// - Captures C and returns it with the echoed operands through a valid/ready response port.
// - Sits between a control/stimulus source and the combinational ALU.
// - Replaces hand-written operand sequencing in benches and datapaths.
//
// PARAMETERS
// WIDTH          4  operand/result width; must match the Pre_Alu instance
// SETTLE_CYCLES  2  cycles between driving alu_* and capturing alu_c; must be >=1
// COUNT_W        8  width of the completed-operation counter
//
// PORTS
// clk        in   1        clock, rising edge
// rst        in   1        asynchronous reset, active-high
// req_valid  in   1        request valid
// req_ready  out  1        request accepted when req_valid && req_ready
// req_a      in   WIDTH    operand A
// req_b      in   WIDTH    operand B
// req_sel    in   1        0 = add, 1 = subtract
// alu_a      out  WIDTH    to Pre_Alu A
// alu_b      out  WIDTH    to Pre_Alu B
// alu_sel    out  1        to Pre_Alu Sel
// alu_c      in   WIDTH    from Pre_Alu C
// rsp_valid  out  1        response valid
// rsp_ready  in   1        response consumed when rsp_valid && rsp_ready
// rsp_a      out  WIDTH    echoed A
// rsp_b      out  WIDTH    echoed B
// rsp_sel    out  1        echoed Sel
// rsp_c      out  WIDTH    captured result
// rsp_err    out  1        result mismatch flag (see CONFIGURATION)
// busy       out  1        state != IDLE
// op_count   out  COUNT_W  completed responses, wraps modulo 2^COUNT_W
//
// BEHAVIOUR
// - Reset: all registered outputs are 0; state = IDLE; settle counter = 0.
//   - req_ready = 1 while rst is low and state is IDLE.
// - FSM states: IDLE, SETTLE, RESP.
//   - IDLE: req_ready = 1 (combinational from state).
//     - On accept edge E0: alu_a, alu_b, alu_sel and rsp_a, rsp_b, rsp_sel load the request.
//     - cnt <= SETTLE_CYCLES-1; go to SETTLE.
//   - SETTLE: req_ready = 0.
//     - cnt != 0: cnt decrements each edge.
//     - cnt == 0: rsp_c <= alu_c; rsp_valid <= 1; go to RESP.
//     - rsp_valid rises at edge E0+SETTLE_CYCLES.
//   - RESP: rsp_* are held stable while rsp_ready = 0.
//     - On handshake: rsp_valid <= 0; op_count += 1; go to IDLE.
// - No overlap: at most one operation in flight.
//   - The next request can be accepted on the cycle after the response handshake.
// - alu_* hold their last values between operations. They change only on accept or reset.
// - Request fields are ignored when req_ready = 0, even if req_valid is asserted.
// - op_count wraps from 2^COUNT_W-1 to 0 with no flag.
// - Reset mid-operation (SETTLE or RESP):
//   - The operation is discarded immediately and no response is produced.
//   - op_count is cleared.
//
// CONFIGURATION
// ALU_SEQ_RESULT_CHECK_EN
// - Defined:
//   - At the capture edge, rsp_err <= (alu_c != exp).
//   - exp = alu_sel ? alu_a - alu_b : alu_a + alu_b, truncated to WIDTH.
//   - rsp_err holds with rsp_c and clears on the response handshake.
//   - A mismatch does not stall the FSM.
// - Not defined:
//   - No checker logic is built.
//   - rsp_err is tied to 0.
//   - Port list is unchanged.
//
// TESTING
// 1. Reset: assert rst during SETTLE -> rsp_valid=0, busy=0, op_count=0, alu_*=0;
//    after release req_ready=1 and no response appears.
// 2. A=5, B=10, Sel=0 -> rsp_valid exactly 2 cycles after accept; rsp_c=15; op_count=1.
// 3. A=8, B=4, Sel=1; rsp_ready held low for 5 cycles -> rsp_c=4.
//    rsp_* stay stable, req_ready=0, and a request offered meanwhile is not taken.
// 4. Back-to-back: A=6, B=3, Sel=1 gives 3; then A=5, B=10, Sel=1 gives 11 (wrap).
//    Second accept occurs the cycle after the first response handshake.
// 5. Check enabled, Pre_Alu stub forcing C=0: A=5, B=10, Sel=0 -> rsp_err=1.
//    rsp_err returns to 0 after the handshake; check disabled -> rsp_err=0.
// 6. COUNT_W=2: complete 4 operations -> op_count reads 1, 2, 3, 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Initiator for a combinational Pre_Alu: takes one request, drives it, waits SETTLE_CYCLES,
// captures C and returns it. Optional result checker: define ALU_SEQ_RESULT_CHECK_EN.
module alu_op_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               req_sel,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_sel,
  input  logic [WIDTH-1:0]   alu_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_a,
  output logic [WIDTH-1:0]   rsp_b,
  output logic               rsp_sel,
  output logic [WIDTH-1:0]   rsp_c,
  output logic               rsp_err,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic               alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]   rsp_a_q, rsp_a_d;
  logic [WIDTH-1:0]   rsp_b_q, rsp_b_d;
  logic               rsp_sel_q, rsp_sel_d;
  logic [WIDTH-1:0]   rsp_c_q, rsp_c_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;
  logic               capture;
  logic               rsp_hs;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_c_d     = rsp_c_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    capture     = 1'b0;
    rsp_hs      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          alu_a_d   = req_a;
          alu_b_d   = req_b;
          alu_sel_d = req_sel;
          rsp_a_d   = req_a;
          rsp_b_d   = req_b;
          rsp_sel_d = req_sel;
          cnt_d     = CntInit;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          capture     = 1'b1;
          rsp_c_d     = alu_c;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_hs      = 1'b1;
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + COUNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_sel_q   <= 1'b0;
      rsp_c_q     <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_c_q     <= rsp_c_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

`ifdef ALU_SEQ_RESULT_CHECK_EN
  logic [WIDTH-1:0] exp_c;
  logic             err_q;

  // Expected result is taken from the operands currently held on alu_*.
  always_comb begin
    exp_c = alu_sel_q ? (alu_a_q - alu_b_q) : (alu_a_q + alu_b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= (alu_c != exp_c);
    end else if (rsp_hs) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign req_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_valid = rsp_valid_q;
  assign op_count  = op_count_q;

endmodule
